rob: RTL
========

ROB -- requirements
Module: rob

Interface
REQ-001 Parameter ROB_SIZE, default 8, number of reorder-buffer entries (power of two).
REQ-002 Parameter ROB_ID_WIDTH, default 4, tag width; tag = entry index + 1; tag 0 means "no pending producer".
REQ-003 Parameter REG_WIDTH, default 5, architectural register index width.
REQ-004 Parameter VAL_WIDTH, default 32, data width.
REQ-005 clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 rst_in  input  1  reset, asynchronous, active-high.
REQ-007 rdy_in  input  1  global enable; when low, all state holds.
REQ-008 flush  input  1  mispredict flush; discards all entries.
REQ-009 issue_en  input  1  decoder requests allocation of one entry.
REQ-010 issue_rd  input  REG_WIDTH  destination register of the issuing instruction.
REQ-011 rob_full  output  1  high when no entry is free (combinational from count).
REQ-012 alloc_tag  output  ROB_ID_WIDTH  tag the next accepted issue receives (tail index + 1).
REQ-013 cdb_en  input  1  result broadcast valid.
REQ-014 cdb_tag  input  ROB_ID_WIDTH  tag of the broadcast result.
REQ-015 cdb_val  input  VAL_WIDTH  broadcast result value.
REQ-016 commit_en  output  1  registered one-cycle pulse per retired entry.
REQ-017 commit_rd  output  REG_WIDTH  destination register of the retired entry.
REQ-018 commit_res  output  VAL_WIDTH  result of the retired entry.
REQ-019 commit_lab  output  ROB_ID_WIDTH  tag of the retired entry.
REQ-020 q_lab1, q_lab2  input  ROB_ID_WIDTH  operand labels read from the register file.
REQ-021 q_rdy1, q_rdy2  output  1  operand value available (label 0 or entry ready).
REQ-022 q_val1, q_val2  output  VAL_WIDTH  operand value from the entry or CDB; 0 when label is 0.

Function
REQ-023 Circular buffer with head, tail and count; per entry: busy, ready, rd, value.
REQ-024 Issue accepted iff rdy_in && issue_en && !rob_full && !flush; entry at tail gets busy=1, ready=0, rd=issue_rd; tail advances modulo ROB_SIZE.
REQ-025 cdb_en with a tag matching a busy entry sets ready=1 and stores cdb_val; non-matching or tag 0 broadcasts are ignored.
REQ-026 Retire when count>0 and head entry ready: next edge commit_en=1, commit_rd/res/lab = head entry, entry freed, head advances; at most one retire per cycle.
REQ-027 A CDB write to the head entry retires no earlier than the following cycle (ready is registered).
REQ-028 Simultaneous accepted issue and retire leave count unchanged; issue into the slot freed in the same cycle is not permitted (full is evaluated before the edge).
REQ-029 Entries with rd=0 retire normally; commit_rd=0 is driven and the register file ignores it.
REQ-030 Query is combinational: label 0 -> rdy=1, val=0; matching CDB in the same cycle -> rdy=1, val=cdb_val; else rdy/val from entry.
REQ-031 flush (with rdy_in) at an edge: head=tail=count=0, all busy/ready cleared, commit_en=0 on that edge; a retire pending that cycle is dropped.
REQ-032 rdy_in low: no issue, no CDB capture, no retire; commit_en driven 0.
REQ-033 commit_en is high for exactly one cycle per retired entry; outputs hold last values otherwise.

Reset
REQ-034 rst_in high asynchronously clears head, tail, count, all busy/ready bits, commit_en, commit_rd, commit_res, commit_lab to 0; rob_full=0 and alloc_tag=1 during and after reset.
REQ-035 Reset asserted mid-retire suppresses the pulse; first issue after release gets tag 1.

Verification
REQ-036 Issue rd=5 (tag 1), CDB tag1 val 0x1234 next cycle -> commit_en pulse one cycle later with rd=5, res=0x1234, lab=1.
REQ-037 Issue 8 entries without results -> rob_full=1, 9th issue_en ignored, alloc_tag stays 1; complete tag 1 -> after retire rob_full=0, alloc_tag=1 (wrap-around).
REQ-038 Results for tags 3,2 arrive before tag 1 -> no commit until tag 1 ready, then retires 1,2,3 on three consecutive cycles.
REQ-039 q_lab1=2 while cdb_tag=2 val 0xABCD -> q_rdy1=1, q_val1=0xABCD same cycle; q_lab2=0 -> q_rdy2=1, q_val2=0.
REQ-040 Four entries in flight, flush with ready head -> no commit_en, count 0, next issue gets tag 1.
REQ-041 rst_in pulsed between clock edges while entries pending -> all outputs 0 immediately, no commit after release.

Source files
------------

// File: rtl/rob.sv
// Reorder buffer: in-order retirement of out-of-order results, with a CDB
// capture port and two combinational operand-lookup ports.
module rob #(
    parameter int ROB_SIZE     = 8,
    parameter int ROB_ID_WIDTH = 4,
    parameter int REG_WIDTH    = 5,
    parameter int VAL_WIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    flush,
    input  logic                    issue_en,
    input  logic [REG_WIDTH-1:0]    issue_rd,
    output logic                    rob_full,
    output logic [ROB_ID_WIDTH-1:0] alloc_tag,
    input  logic                    cdb_en,
    input  logic [ROB_ID_WIDTH-1:0] cdb_tag,
    input  logic [VAL_WIDTH-1:0]    cdb_val,
    output logic                    commit_en,
    output logic [REG_WIDTH-1:0]    commit_rd,
    output logic [VAL_WIDTH-1:0]    commit_res,
    output logic [ROB_ID_WIDTH-1:0] commit_lab,
    input  logic [ROB_ID_WIDTH-1:0] q_lab1,
    input  logic [ROB_ID_WIDTH-1:0] q_lab2,
    output logic                    q_rdy1,
    output logic                    q_rdy2,
    output logic [VAL_WIDTH-1:0]    q_val1,
    output logic [VAL_WIDTH-1:0]    q_val2
);

    localparam int IDX_W = (ROB_SIZE > 1) ? $clog2(ROB_SIZE) : 1;
    localparam int CNT_W = $clog2(ROB_SIZE + 1);

    localparam logic [IDX_W-1:0]        IDX_ONE  = 1;
    localparam logic [CNT_W-1:0]        CNT_ONE  = 1;
    localparam logic [CNT_W-1:0]        FULL_CNT = CNT_W'(ROB_SIZE);
    localparam logic [ROB_ID_WIDTH-1:0] TAG_ONE  = 1;
    localparam logic [ROB_ID_WIDTH:0]   MAX_TAG  = (ROB_ID_WIDTH+1)'(ROB_SIZE);

    logic [IDX_W-1:0]    head_q, head_d;
    logic [IDX_W-1:0]    tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [ROB_SIZE-1:0] busy_q, busy_d;
    logic [ROB_SIZE-1:0] ready_q, ready_d;

    logic [REG_WIDTH-1:0] rd_q  [ROB_SIZE];
    logic [VAL_WIDTH-1:0] val_q [ROB_SIZE];

    logic                    commit_en_q, commit_en_d;
    logic [REG_WIDTH-1:0]    commit_rd_q, commit_rd_d;
    logic [VAL_WIDTH-1:0]    commit_res_q, commit_res_d;
    logic [ROB_ID_WIDTH-1:0] commit_lab_q, commit_lab_d;

    logic             issue_ok;
    logic             retire_ok;
    logic             cdb_hit;
    logic [IDX_W-1:0] cdb_idx;

    // Tag 0 means "no producer"; tags above ROB_SIZE never name an entry.
    function automatic logic tag_valid(input logic [ROB_ID_WIDTH-1:0] tag);
        return (tag != '0) && ({1'b0, tag} <= MAX_TAG);
    endfunction

    function automatic logic [IDX_W-1:0] tag_idx(input logic [ROB_ID_WIDTH-1:0] tag);
        logic [ROB_ID_WIDTH-1:0] t;
        t = tag - TAG_ONE;
        return t[IDX_W-1:0];
    endfunction

    // Operand lookup: {ready, value}; a same-cycle CDB broadcast bypasses the entry.
    function automatic logic [VAL_WIDTH:0] lookup(input logic [ROB_ID_WIDTH-1:0] lab);
        logic [VAL_WIDTH:0] r;
        r = '0;
        if (lab == '0) begin
            r[VAL_WIDTH] = 1'b1;
        end else if (cdb_en && (cdb_tag == lab)) begin
            r = {1'b1, cdb_val};
        end else if (tag_valid(lab)) begin
            r = {ready_q[tag_idx(lab)], val_q[tag_idx(lab)]};
        end
        return r;
    endfunction

    assign rob_full  = (count_q == FULL_CNT);
    assign alloc_tag = ROB_ID_WIDTH'(tail_q) + TAG_ONE;

    assign cdb_idx   = tag_idx(cdb_tag);
    assign issue_ok  = rdy_in && issue_en && !rob_full && !flush;
    assign retire_ok = rdy_in && !flush && (count_q != '0) && ready_q[head_q];
    assign cdb_hit   = rdy_in && !flush && cdb_en && tag_valid(cdb_tag) && busy_q[cdb_idx];

    always_comb begin
        {q_rdy1, q_val1} = lookup(q_lab1);
        {q_rdy2, q_val2} = lookup(q_lab2);
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        busy_d  = busy_q;
        ready_d = ready_q;
        if (rdy_in && flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            busy_d  = '0;
            ready_d = '0;
        end else begin
            if (cdb_hit) begin
                ready_d[cdb_idx] = 1'b1;
            end
            if (retire_ok) begin
                busy_d[head_q]  = 1'b0;
                ready_d[head_q] = 1'b0;
                head_d          = head_q + IDX_ONE;
            end
            // Full is judged on the current count, so the tail never reuses the slot freed this edge.
            if (issue_ok) begin
                busy_d[tail_q]  = 1'b1;
                ready_d[tail_q] = 1'b0;
                tail_d          = tail_q + IDX_ONE;
            end
            case ({issue_ok, retire_ok})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        commit_en_d  = retire_ok;
        commit_rd_d  = commit_rd_q;
        commit_res_d = commit_res_q;
        commit_lab_d = commit_lab_q;
        if (retire_ok) begin
            commit_rd_d  = rd_q[head_q];
            commit_res_d = val_q[head_q];
            commit_lab_d = ROB_ID_WIDTH'(head_q) + TAG_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            busy_q       <= '0;
            ready_q      <= '0;
            commit_en_q  <= 1'b0;
            commit_rd_q  <= '0;
            commit_res_q <= '0;
            commit_lab_q <= '0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            busy_q       <= busy_d;
            ready_q      <= ready_d;
            commit_en_q  <= commit_en_d;
            commit_rd_q  <= commit_rd_d;
            commit_res_q <= commit_res_d;
            commit_lab_q <= commit_lab_d;
        end
    end

    // Entry payload is qualified by busy/ready, so it needs no reset.
    always_ff @(posedge clk) begin
        if (issue_ok) begin
            rd_q[tail_q] <= issue_rd;
        end
        if (cdb_hit) begin
            val_q[cdb_idx] <= cdb_val;
        end
    end

    assign commit_en  = commit_en_q;
    assign commit_rd  = commit_rd_q;
    assign commit_res = commit_res_q;
    assign commit_lab = commit_lab_q;

endmodule
